// File: rtl/network_seq_pkg.sv
// Shared types and helpers for the frame-level network sequencer.
// Holds the sequencer state encoding and the phase-counter width rule.
package network_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    RUN,
    DONE
  } seq_state_t;

  // Wide enough to hold the longer of the flush and run phases.
  function automatic int phase_width(input int window, input int flush);
    return $clog2(((window > flush) ? window : flush) + 1);
  endfunction

endpackage

// File: rtl/spike_counter.sv
// Rising-edge detector on the network spike line feeding a saturating counter.
// count is combinational and already includes the current cycle's edge.
module spike_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             spike,
  output logic [CNT_W-1:0] count
);

  logic             spike_prev;
  logic [CNT_W-1:0] cnt_q;
  logic             rise;

  assign rise  = en && spike && !spike_prev;
  assign count = (rise && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q      <= '0;
      spike_prev <= 1'b0;
    end else if (en) begin
      cnt_q      <= count;
      spike_prev <= spike;
    end
  end

endmodule

// File: rtl/network_sequencer.sv
// Frame controller: accepts a pixel vector, flushes the network in reset,
// runs it for a fixed window while counting spikes, then returns one result.
module network_sequencer #(
  parameter int HEIGHT = 7,
  parameter int BAL_W  = 11,
  parameter int WINDOW = 14336,
  parameter int FLUSH  = 7,
  parameter int THRESH = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [HEIGHT-1:0] in_pixels,
  input  logic              abort,
  output logic              net_rst_n,
  output logic [HEIGHT-1:0] net_pixels,
  input  logic              net_spike,
  input  logic [BAL_W-1:0]  net_balance,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CNT_W-1:0]  res_count,
  output logic [BAL_W-1:0]  res_balance,
  output logic              res_fire,
  output logic              busy
);

  import network_seq_pkg::*;

  // The FLUSH parameter shadows the package literal, so alias the state.
  localparam seq_state_t ST_FLUSH = network_seq_pkg::FLUSH;
  localparam int PH_W = phase_width(WINDOW, FLUSH);

  seq_state_t       state, state_next;
  logic [PH_W-1:0]  phase;
  logic             phase_done;
  logic             last_run;
  logic [CNT_W-1:0] spike_count;

  assign phase_done = (phase == '0);
  assign last_run   = (state == RUN) && phase_done && !abort;

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign net_rst_n = (state == RUN);
  assign res_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:     if (in_valid) state_next = ST_FLUSH;
      ST_FLUSH: if (abort) state_next = IDLE;
                else if (phase_done) state_next = RUN;
      RUN:      if (abort) state_next = IDLE;
                else if (phase_done) state_next = DONE;
      DONE:     if (abort || res_ready) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Phase counts down to zero and reloads whenever the state changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= '0;
    end else if (state_next != state) begin
      phase <= (state_next == RUN) ? PH_W'(WINDOW - 1) : PH_W'(FLUSH - 1);
    end else if (!phase_done) begin
      phase <= phase - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      net_pixels  <= '0;
      res_count   <= '0;
      res_balance <= '0;
      res_fire    <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) net_pixels <= in_pixels;
      if (last_run) begin
        res_count   <= spike_count;
        res_balance <= net_balance;
        res_fire    <= (32'(spike_count) >= 32'(THRESH));
      end
    end
  end

  // Held cleared outside RUN, so every window starts with a fresh count.
  spike_counter #(
    .CNT_W(CNT_W)
  ) u_spike_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (state != RUN),
    .en   (state == RUN),
    .spike(net_spike),
    .count(spike_count)
  );

endmodule

// File: doc/network_sequencer.md
Name: network_sequencer

Overview:
- Frame-level controller for the spiking pixel-classification network.
- Accepts one pixel vector per frame over a valid/ready handshake and holds the network in reset for a flush period.
- Applies the pixels for a fixed window of clk cycles, counts output spikes, captures the final balance and returns one result per frame over a valid/ready handshake.
- Sits between the JTAG command interface and the network instance; it is the only driver of the network's reset and pixel inputs.

Parameters:
- HEIGHT, 7, number of pixel inputs and network rows.
- BAL_W, 11, width of the network balance bus.
- WINDOW, 14336, clk cycles the network runs per frame (≥1).
- FLUSH, 7, clk cycles the network is held in reset before each run (≥1).
- THRESH, 4, spike count at or above which res_fire=1.
- CNT_W, 16, width of the spike counter; count saturates at 2^CNT_W-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  frame request valid.
- in_ready  out  1  sequencer can accept a frame.
- in_pixels  in  HEIGHT  binary pixel vector for the frame.
- abort  in  1  cancel the current frame; no result is produced.
- net_rst_n  out  1  active-low reset to the network.
- net_pixels  out  HEIGHT  pixels driven into the network.
- net_spike  in  1  network neuron_out.
- net_balance  in  BAL_W  network balance_out.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumer ready.
- res_count  out  CNT_W  rising edges of net_spike seen in the window.
- res_balance  out  BAL_W  net_balance sampled on the last RUN cycle.
- res_fire  out  1  res_count ≥ THRESH.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; in_ready=1; net_rst_n=0; net_pixels=0.
  - res_valid=0, res_count=0, res_balance=0, res_fire=0; counters=0; spike edge-detect history=0.
  - Reset takes priority over every other input, including mid-frame.
- States: IDLE, FLUSH, RUN, DONE.
- IDLE:
  - in_ready=1, net_rst_n=0.
  - On in_valid: latch in_pixels into net_pixels, clear spike counter, go to FLUSH.
- FLUSH:
  - net_rst_n=0; lasts exactly FLUSH cycles, then go to RUN.
- RUN:
  - net_rst_n=1; lasts exactly WINDOW cycles.
  - Each cycle: if net_spike=1 and the previous-cycle sample=0, increment the counter, saturating at max.
  - Edge history is cleared on entry to RUN, so a spike high on the first RUN cycle counts.
  - A spike on the last RUN cycle counts.
  - On the last RUN cycle, register res_balance=net_balance and res_count=final count (including that cycle's edge). Set res_fire, go to DONE.
- DONE:
  - res_valid=1; net_rst_n=0; net_pixels held.
  - Results stay stable until res_valid&res_ready, then go to IDLE with res_valid=0 the next cycle.
  - in_ready=0 in DONE; no same-cycle accept.
- Latency: handshake accepted at edge t.
  - net_rst_n=0 for edges t+1..t+FLUSH.
  - net_rst_n=1 for cycles t+FLUSH+1..t+FLUSH+WINDOW.
  - res_valid=1 from cycle t+FLUSH+WINDOW+1.
- in_ready=0 in FLUSH, RUN and DONE; in_valid there is ignored and not queued.
- abort:
  - In FLUSH or RUN: next state IDLE, net_rst_n=0, no result, outputs unchanged.
  - In DONE: discard the result, res_valid=0, go to IDLE.
  - In IDLE: ignored. If abort and in_valid are both high in IDLE, the frame is accepted.
- In DONE, abort wins over res_ready.
- Phase counter width: $clog2(max(WINDOW,FLUSH)+1). It reloads on every state entry.

Decomposition:
- Package network_seq_pkg:
  - seq_state_t enum {IDLE, FLUSH, RUN, DONE}.
  - Localparam helper for the phase-counter width.
- Sub-module spike_counter (clk, rst, clr, en, spike, count):
  - Rising-edge detect plus saturating CNT_W counter.
  - clr clears both the count and the edge history.

Test Plan (bench params WINDOW=16, FLUSH=7, THRESH=3, CNT_W=4):
- Reset then idle → in_ready=1, net_rst_n=0, res_valid=0, busy=0, all result outputs 0.
- Frame 7'b0101010 at t; net_spike pulses 1 cycle at RUN cycles 1, 5, 16 → net_rst_n=0 for t+1..t+7, 1 for t+8..t+23; res_valid at t+24; res_count=3; res_fire=1; net_pixels=7'b0101010 throughout.
- net_spike held high for all 16 RUN cycles; net_balance=11'd300 on last RUN cycle → res_count=1, res_fire=0, res_balance=300.
- 8 one-cycle pulses every other cycle, res_ready low for 5 cycles after res_valid, in_valid held high throughout → res_count=8 held stable 5 cycles; second frame accepted only in the cycle after the result handshake returns to IDLE; CNT_W=3 variant saturates at 7.
- abort at RUN cycle 4 → IDLE next cycle, res_valid never asserts, next frame's count starts at 0; rst asserted mid-FLUSH → same reset values as scenario 1.
